// File: rtl/alu2_sequencer_if.sv
// alu2_sequencer_if
// Groups the two buses of the sequencer:
//   - instruction handshake: instr_valid / instr_data in, instr_ready out
//   - ALU drive/return lines: i1,i0,a1,a0,b1,b0 out, f1,f0,error in
// master : host + external ALU side (drives instructions and ALU results)
// slave  : the sequencer
interface alu2_sequencer_if;
    logic       instr_valid;
    logic [3:0] instr_data;     // [3:2] = op, [1:0] = b
    logic       instr_ready;
    logic       i1, i0;
    logic       a1, a0;
    logic       b1, b0;
    logic       f1, f0;
    logic       error;

    modport master (
        output instr_valid, instr_data, f1, f0, error,
        input  instr_ready, i1, i0, a1, a0, b1, b0
    );

    modport slave (
        input  instr_valid, instr_data, f1, f0, error,
        output instr_ready, i1, i0, a1, a0, b1, b0
    );
endinterface

// File: rtl/alu2_sequencer.sv
// alu2_sequencer
// Buffers a host-written program of {op, b} instructions and runs it against
// an external 2-bit combinational ALU, with a 2-bit accumulator as operand a.
// Each instruction takes two cycles: ISSUE drives op/b onto the ALU lines,
// CAPTURE samples f back into the accumulator. An add overflow or subtract
// underflow halts the sequencer with a sticky error until clear.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   start          begin execution (honoured only in IDLE)
//   acc_init       accumulator value loaded on an accepted start
//   clear          leave HALT, clear the error, flush the buffer
//   bus            instruction handshake + ALU lines (slave modport)
//   acc            accumulator
//   busy           high while in ISSUE or CAPTURE
//   done           one-cycle pulse when the program completes
//   err_flag       sticky error
//   err_op         op that raised the error
module alu2_sequencer #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [1:0]             acc_init,
    input  logic                   clear,
    alu2_sequencer_if.slave        bus,
    output logic [1:0]             acc,
    output logic                   busy,
    output logic                   done,
    output logic                   err_flag,
    output logic [1:0]             err_op
);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        HALT    = 2'd3
    } state_t;

    state_t           state_reg;
    logic [3:0]       mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [CNT_W-1:0] count_reg;

    logic             wr_en;
    logic             pop;
    logic             flush;
    logic             buf_empty;

    // Ready already excludes HALT, so a handshake is always a legal write.
    assign bus.instr_ready = (count_reg != FULL_COUNT) && (state_reg != HALT);
    assign wr_en           = bus.instr_valid && bus.instr_ready;
    assign pop             = (state_reg == ISSUE);
    assign flush           = (state_reg == HALT) && clear;
    assign buf_empty       = (count_reg == '0);

    // Operand a is the accumulator itself.
    assign bus.a1 = acc[1];
    assign bus.a0 = acc[0];

    // Instruction storage; head is read with a register stage in ISSUE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                mem[k] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_ptr_reg] <= bus.instr_data;
        end
    end

    // Pointers wrap naturally at PTR_W bits; a simultaneous write and pop
    // leaves the count unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            case ({wr_en, pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Control FSM with registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            acc       <= '0;
            bus.i1    <= 1'b0;
            bus.i0    <= 1'b0;
            bus.b1    <= 1'b0;
            bus.b0    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err_flag  <= 1'b0;
            err_op    <= '0;
        end else begin
            done <= 1'b0;
            case (state_reg)
                IDLE: begin
                    busy <= 1'b0;
                    if (start) begin
                        acc <= acc_init;
                        if (buf_empty) begin
                            done <= 1'b1;
                        end else begin
                            state_reg <= ISSUE;
                            busy      <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    {bus.i1, bus.i0} <= mem[rd_ptr_reg][3:2];
                    {bus.b1, bus.b0} <= mem[rd_ptr_reg][1:0];
                    state_reg        <= CAPTURE;
                    busy             <= 1'b1;
                end
                CAPTURE: begin
                    // Error only matters for add/sub, i.e. op[1] set.
                    if (bus.error && bus.i1) begin
                        err_flag  <= 1'b1;
                        err_op    <= {bus.i1, bus.i0};
                        state_reg <= HALT;
                        busy      <= 1'b0;
                    end else begin
                        acc <= {bus.f1, bus.f0};
                        if (buf_empty) begin
                            state_reg <= IDLE;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                        end else begin
                            state_reg <= ISSUE;
                            busy      <= 1'b1;
                        end
                    end
                end
                HALT: begin
                    busy <= 1'b0;
                    if (clear) begin
                        err_flag  <= 1'b0;
                        err_op    <= '0;
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    busy      <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu2_sequencer.sv
// tb_alu2_sequencer
// Directed test of alu2_sequencer with a behavioural model of the 2-bit ALU
// closing the loop. Inputs are driven and outputs sampled on the falling edge.
module tb_alu2_sequencer;
    logic       clk;
    logic       rst_n;
    logic       start;
    logic [1:0] acc_init;
    logic       clear;
    logic [1:0] acc;
    logic       busy;
    logic       done;
    logic       err_flag;
    logic [1:0] err_op;
    logic       force_err;

    int checks;
    int errors;
    int acc_log [0:31];
    int done_at;
    int busy_cnt;

    alu2_sequencer_if bus ();

    alu2_sequencer #(.DEPTH(4), .PTR_W(2)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .acc_init (acc_init),
        .clear    (clear),
        .bus      (bus),
        .acc      (acc),
        .busy     (busy),
        .done     (done),
        .err_flag (err_flag),
        .err_op   (err_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External ALU: 00 NOT a, 01 a AND b, 10 a+b (overflow), 11 a-b (underflow).
    logic [1:0] alu_a, alu_b, alu_f;
    logic [2:0] alu_sum;
    logic       alu_err;
    always_comb begin
        alu_a   = {bus.a1, bus.a0};
        alu_b   = {bus.b1, bus.b0};
        alu_f   = 2'b00;
        alu_sum = 3'b000;
        alu_err = 1'b0;
        case ({bus.i1, bus.i0})
            2'b00: alu_f = ~alu_a;
            2'b01: alu_f = alu_a & alu_b;
            2'b10: begin
                alu_sum = {1'b0, alu_a} + {1'b0, alu_b};
                alu_f   = alu_sum[1:0];
                alu_err = alu_sum[2];
            end
            default: begin
                alu_f   = alu_a - alu_b;
                alu_err = (alu_a < alu_b);
            end
        endcase
        bus.f1    = alu_f[1];
        bus.f0    = alu_f[0];
        bus.error = alu_err | force_err;
    end

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Offer one instruction for one clock (called on a falling edge).
    task automatic push(input logic [3:0] d);
        $display("push op=%b b=%b ready=%b", d[3:2], d[1:0], bus.instr_ready);
        bus.instr_valid = 1'b1;
        bus.instr_data  = d;
        @(negedge clk);
        bus.instr_valid = 1'b0;
    endtask

    task automatic do_start(input logic [1:0] init);
        $display("start acc_init=%b", init);
        start    = 1'b1;
        acc_init = init;
        @(negedge clk);
        start    = 1'b0;
    endtask

    task automatic do_clear();
        $display("clear");
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    // Watch a run starting at the falling edge after the start edge (k=1).
    // Optionally inject one instruction offered on falling edge inject_at.
    task automatic run_watch(input int max_cyc, input int inject_at,
                             input logic [3:0] inject_data,
                             output int d_at, output int b_cnt);
        d_at  = -1;
        b_cnt = 0;
        for (int k = 1; k <= max_cyc; k++) begin
            bus.instr_valid = (k == inject_at);
            bus.instr_data  = inject_data;
            acc_log[k]      = int'(acc);
            if (busy) b_cnt++;
            if (done) begin
                d_at = k;
                break;
            end
            if (k < max_cyc) @(negedge clk);
        end
        bus.instr_valid = 1'b0;
        $display("run done_at=%0d busy_cycles=%0d acc=%b", d_at, b_cnt, acc);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks          = 0;
        errors          = 0;
        rst_n           = 1'b0;
        start           = 1'b0;
        acc_init        = 2'b00;
        clear           = 1'b0;
        force_err       = 1'b0;
        bus.instr_valid = 1'b0;
        bus.instr_data  = 4'b0000;
        repeat (2) @(negedge clk);

        // Reset state
        check("rst_acc", acc, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err_flag", err_flag, 0);
        check("rst_err_op", err_op, 0);
        check("rst_alu_lines", {bus.i1, bus.i0, bus.a1, bus.a0, bus.b1, bus.b0}, 0);
        check("rst_ready", bus.instr_ready, 1);
        rst_n = 1'b1;
        @(negedge clk);

        // Program: acc 00 +01 -> 01, +01 -> 10, AND 10 -> 10
        push(4'b1001);
        push(4'b1001);
        push(4'b0110);
        do_start(2'b00);
        run_watch(20, 0, 4'b0000, done_at, busy_cnt);
        check("prog_done_at", done_at, 7);
        check("prog_busy_cycles", busy_cnt, 6);
        check("prog_acc1", acc_log[3], 1);
        check("prog_acc2", acc_log[5], 2);
        check("prog_acc3", acc_log[7], 2);
        @(negedge clk);
        check("prog_done_pulse", done, 0);

        // Overflow: 11 + 01 halts, second instruction never issued
        push(4'b1001);
        push(4'b0000);
        do_start(2'b11);
        run_watch(6, 0, 4'b0000, done_at, busy_cnt);
        check("ovf_no_done", done_at, -1);
        check("ovf_err_flag", err_flag, 1);
        check("ovf_err_op", err_op, 2);
        check("ovf_acc", acc, 3);
        check("ovf_ready", bus.instr_ready, 0);
        check("ovf_busy", busy, 0);
        check("ovf_op_lines", {bus.i1, bus.i0, bus.b1, bus.b0}, 4'b1001);
        push(4'b0100);
        do_clear();
        check("clr_err_flag", err_flag, 0);
        check("clr_err_op", err_op, 0);
        check("clr_ready", bus.instr_ready, 1);
        check("clr_acc_hold", acc, 3);

        // Empty start (buffer flushed by clear, blocked write not stored)
        do_start(2'b10);
        check("empty_done", done, 1);
        check("empty_acc", acc, 2);
        check("empty_busy", busy, 0);
        @(negedge clk);
        check("empty_done_pulse", done, 0);
        check("empty_busy2", busy, 0);

        // Underflow: 00 - 01
        push(4'b1101);
        do_start(2'b00);
        run_watch(4, 0, 4'b0000, done_at, busy_cnt);
        check("udf_no_done", done_at, -1);
        check("udf_err_flag", err_flag, 1);
        check("udf_err_op", err_op, 3);
        check("udf_acc", acc, 0);
        do_clear();
        check("udf_clr_err", err_flag, 0);

        // NOT with error forced high: error ignored
        force_err = 1'b1;
        push(4'b0000);
        do_start(2'b01);
        run_watch(6, 0, 4'b0000, done_at, busy_cnt);
        check("not_done_at", done_at, 3);
        check("not_acc", acc, 2);
        check("not_err_flag", err_flag, 0);
        force_err = 1'b0;
        @(negedge clk);

        // Full buffer, refused 5th write, write-with-pop across wrap
        check("full_ready0", bus.instr_ready, 1);
        push(4'b1001);
        check("full_ready1", bus.instr_ready, 1);
        push(4'b1010);
        check("full_ready2", bus.instr_ready, 1);
        push(4'b0000);
        check("full_ready3", bus.instr_ready, 1);
        push(4'b1010);
        check("full_ready4", bus.instr_ready, 0);
        push(4'b0011);
        do_start(2'b00);
        run_watch(30, 3, 4'b1101, done_at, busy_cnt);
        check("wrap_done_at", done_at, 11);
        check("wrap_busy_cycles", busy_cnt, 10);
        check("wrap_acc1", acc_log[3], 1);
        check("wrap_acc2", acc_log[5], 3);
        check("wrap_acc3", acc_log[7], 0);
        check("wrap_acc4", acc_log[9], 2);
        check("wrap_acc5", acc_log[11], 1);
        check("wrap_err_flag", err_flag, 0);
        @(negedge clk);

        // Reset in the middle of CAPTURE
        push(4'b0111);
        push(4'b0111);
        do_start(2'b11);
        @(negedge clk);
        check("mid_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_acc", acc, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_err_flag", err_flag, 0);
        check("mid_rst_alu_lines", {bus.i1, bus.i0, bus.a1, bus.a0, bus.b1, bus.b0}, 0);
        check("mid_rst_ready", bus.instr_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_start(2'b10);
        check("post_rst_done", done, 1);
        check("post_rst_acc", acc, 2);
        check("post_rst_busy", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
